// File: rtl/loader_pkg.sv
// loader_pkg: shared states, status codes and widths for the program loader
package loader_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] TMO = 2'b01;
  localparam logic [1:0] OVF = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, GAP, START, RUN, RESULT} state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams program words into code memory, starts the unit and reports its result
module program_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] datain,
  output logic              start,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] out_i,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_status,
  output logic [15:0]       r_cycles,
  output logic              busy
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [DATA_W-1:0] datain_q, datain_d, rdata_q, rdata_d;
  logic [1:0] status_q, status_d;
  logic [15:0] cyc_q, cyc_d, cyc_inc;
  logic wr_q, wr_d, gap_q, gap_d, acc;

  always_comb begin
    s_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
    acc = s_valid && s_ready;
    start = (state_q == START) && ready_i;
    busy = state_q != IDLE;
    r_valid = state_q == RESULT;
    cyc_inc = &cyc_q ? cyc_q : cyc_q + 16'd1;
    state_d = state_q;
    idx_d = idx_q;
    wr_d = 1'b0;
    addr_d = addr_q;
    datain_d = datain_q;
    gap_d = gap_q;
    rdata_d = rdata_q;
    status_d = status_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE, LOAD: if (acc) begin
        wr_d = 1'b1;
        addr_d = idx_q;
        datain_d = s_data;
        idx_d = idx_q + 10'd1;
        gap_d = 1'b0;
        if (state_q == IDLE) begin
          status_d = OK;
          rdata_d = '0;
          cyc_d = '0;
        end
        // the last memory slot filled without s_last: drop the rest of the stream
        if (!s_last && &idx_q) status_d = OVF;
        state_d = s_last ? GAP : (&idx_q ? DRAIN : LOAD);
      end
      DRAIN: if (acc && s_last) begin
        state_d = RESULT;
        rdata_d = '0;
      end
      GAP: begin
        gap_d = 1'b1;
        state_d = gap_q ? START : GAP;
      end
      START: if (ready_i) begin
        state_d = RUN;
        cyc_d = '0;
      end
      RUN: begin
        cyc_d = cyc_inc;
        // cyc_q is still zero in the acknowledge cycle, where ready_i is stale
        if ((cyc_q != 16'd0 && ready_i) || cyc_inc >= TIMEOUT) begin
          state_d = RESULT;
          rdata_d = out_i;
          status_d = (cyc_q != 16'd0 && ready_i) ? OK : TMO;
        end
      end
      RESULT: if (r_ready) begin
        state_d = IDLE;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      datain_q <= '0;
      gap_q <= 1'b0;
      rdata_q <= '0;
      status_q <= OK;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      datain_q <= datain_d;
      gap_q <= gap_d;
      rdata_q <= rdata_d;
      status_q <= status_d;
      cyc_q <= cyc_d;
    end

  assign wr = wr_q;
  assign addr = addr_q;
  assign datain = datain_q;
  assign r_data = rdata_q;
  assign r_status = status_q;
  assign r_cycles = cyc_q;
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16'hFFFF, giving the maximum number of run cycles allowed from start to ready_i return.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, 16) and s_last (input, 1), forming the program-word input stream; s_last marks the final word.
REQ-005 The module SHALL have ports wr (output, 1), addr (output, 10) and datain (output, 16), forming the code-memory write port toward the processing unit.
REQ-006 The module SHALL have port start (output, 1): a one-cycle run request to the processing unit.
REQ-007 The module SHALL have port ready_i (input, 1): the processing unit's ready flag.
REQ-008 The module SHALL have port out_i (input, 16): the processing unit's stack-top result.
REQ-009 The module SHALL have ports r_valid (output, 1), r_ready (input, 1), r_data (output, 16), r_status (output, 2) and r_cycles (output, 16), forming the result stream.
REQ-010 The module SHALL have port busy (output, 1): high in every state except IDLE.

Function
REQ-011 The FSM SHALL use the states IDLE, LOAD, DRAIN, GAP, START, RUN and RESULT.
REQ-012 In IDLE and LOAD, s_ready SHALL be 1; in all other states, s_ready SHALL be 0, except in DRAIN, where it is also 1.
REQ-013 Each accepted beat (s_valid & s_ready) SHALL drive wr=1, addr=word index and datain=s_data, registered, for exactly one following cycle; the word index is 0 for the first beat and increments by 1 per beat.
REQ-014 The first accepted beat in IDLE SHALL move the FSM to LOAD; a beat with s_last=1 SHALL move it to GAP.
REQ-015 When a beat is accepted at index 1023 with s_last=0, the FSM SHALL go to DRAIN, latch status 2'b10 (overflow) and write no further words.
REQ-016 DRAIN SHALL discard beats until s_last is accepted, then go to RESULT with r_data=0; start is never issued.
REQ-017 GAP SHALL last exactly 2 cycles with wr=0, so that the processing unit commits the last registered write before start is sampled.
REQ-018 START SHALL wait for ready_i=1 and then assert start for exactly one cycle, clearing r_cycles to 0.
REQ-019 start and wr SHALL never both be 1 in the same cycle.
REQ-020 RUN SHALL ignore ready_i during the first cycle after start (the acknowledge cycle).
REQ-021 From the second cycle after start onward, RUN SHALL capture out_i into r_data and go to RESULT with status 2'b00 on ready_i=1.
REQ-022 r_cycles SHALL count cycles from start to ready_i return, saturating at 16'hFFFF.
REQ-023 When r_cycles reaches TIMEOUT in RUN, the FSM SHALL go to RESULT with status 2'b01 and r_data=out_i.
REQ-024 In RESULT, r_valid SHALL be 1 and r_data, r_status and r_cycles SHALL be held stable until r_ready=1.
REQ-025 On r_valid & r_ready, the FSM SHALL return to IDLE and reset the word index to 0.
REQ-026 An s_valid beat arriving outside IDLE, LOAD or DRAIN SHALL stall (s_ready=0) and never be lost.
REQ-027 A single-word program (s_last on beat 0) SHALL be valid: one write to addr 0, then GAP.

Reset
REQ-028 While nrst=0, the FSM SHALL be in IDLE with s_ready=1, and wr, start, r_valid and busy SHALL be 0.
REQ-029 While nrst=0, addr, datain, r_data, r_status, r_cycles and the word index SHALL all be 0.
REQ-030 Reset assertion mid-LOAD or mid-RUN SHALL abort immediately with no further wr or start pulses; the partially written program is abandoned.

Structure
REQ-031 Shared package loader_pkg SHALL hold the state enum, the status codes OK=2'b00, TMO=2'b01 and OVF=2'b10, ADDR_W=10 and DATA_W=16.
REQ-032 The block SHALL be flat with no sub-module; the run/timeout counter is inline.

Verification
REQ-033 Stream 0x0003, 0x0004, 0x8002 (add), 0xC000 (halt, s_last) -> four wr pulses at addr 0..3, then start 3 cycles after the last beat, then r_data=7, r_status=00.
REQ-034 Program 0x0005, 0xC000 with r_ready held 0 for 10 cycles -> r_valid stays high and r_data=5 stays stable, s_ready=0 throughout, then return to IDLE after r_ready=1.
REQ-035 1030 beats with s_last on the last beat -> wr pulses only for addr 0..1023, all beats consumed, r_status=10, start never asserted.
REQ-036 TIMEOUT=20 with a program that never halts (0x0000 repeated to the end of memory) -> r_status=01 and r_cycles=20.
REQ-037 nrst pulled low during the third beat of a load -> all outputs at reset values; the next full program runs correctly from addr 0.
REQ-038 ready_i held 0 (processing unit busy from an earlier timeout) when START is reached -> start withheld until ready_i=1, then asserted once.
